sv_uart_tx_arbiter: RTL and testbench

//   Round-robin arbiter that shares one sv_uart_engine transmit AXI-Stream port among NUM_REQ requesters.
//   A grant is held for a whole packet (ends on tlast), or for up to MAX_BURST beats when MAX_BURST>0.
//   The arbiter reports the granted requester index, so the upstream framer can tag or steer traffic.
//   It sits between the requester logic and the engine's s_axis port.
//

---
 rtl/sv_uart_tx_arbiter.sv | 137 +++++++++++++
 tb/tb_sv_uart_tx_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sv_uart_tx_arbiter.sv
// sv_uart_tx_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share the single
//   transmit AXI-Stream input of sv_uart_engine. A grant covers a whole
//   packet (up to tlast). When MAX_BURST > 0, a grant also ends after
//   MAX_BURST beats. Nothing is buffered: the granted requester is passed
//   straight through to the engine.
//
// Ports
//   iclk, irst      clock; asynchronous active-high reset
//   s_axis_tdata    requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid   per-requester valid
//   s_axis_tlast    per-requester end of packet
//   s_axis_tready   per-requester ready (only the granted one can be high)
//   m_axis_tdata    data to the engine
//   m_axis_tvalid   valid to the engine
//   m_axis_tready   ready from the engine
//   m_axis_tid      index of the granted requester
//   ogrant          one-hot grant, all zero while idle
//   obusy           high while a grant is held
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | no grant; pick the next valid requester after the pointer
// S_XFER | granted requester passed through until tlast / burst limit

module sv_uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 24,
  parameter int MAX_BURST  = 0,
  localparam int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                          iclk,
  input  logic                          irst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_REQ-1:0]            s_axis_tvalid,
  input  logic [NUM_REQ-1:0]            s_axis_tlast,
  output logic [NUM_REQ-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [ID_W-1:0]               m_axis_tid,
  output logic [NUM_REQ-1:0]            ogrant,
  output logic                          obusy
);

  localparam logic [0:0]  S_IDLE    = 1'b0;
  localparam logic [0:0]  S_XFER    = 1'b1;
  localparam logic [15:0] BURST_LIM = 16'(MAX_BURST);
  localparam bit          BURST_EN  = (MAX_BURST > 0);

  logic [0:0]         state;
  logic [ID_W-1:0]    ptr;
  logic [15:0]        beat_cnt;
  logic [15:0]        cnt_next;

  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;
  logic [ID_W-1:0]    cand;
  logic [NUM_REQ-1:0] pick_onehot;

  logic               xfer;
  logic               beat;
  logic               last_hit;
  logic               burst_hit;
  logic               release_grant;

  // Scan upward from ptr+1 with wrap-around; the requester that held the
  // last grant (ptr) is visited last, so it has the lowest priority.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    cand        = '0;
    pick_onehot = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!pick_found && s_axis_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_onehot[pick_idx] = 1'b1;
  end

  // Pass-through of the granted requester; everything is gated by the
  // state so nothing leaks through while idle.
  assign xfer          = (state == S_XFER);
  assign obusy         = xfer;
  assign m_axis_tdata  = xfer ? s_axis_tdata[m_axis_tid*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign m_axis_tvalid = xfer & s_axis_tvalid[m_axis_tid];
  assign s_axis_tready = xfer ? (ogrant & {NUM_REQ{m_axis_tready}}) : '0;

  assign beat      = m_axis_tvalid & m_axis_tready;
  assign cnt_next  = (beat_cnt == 16'hFFFF) ? beat_cnt : beat_cnt + 16'd1;
  assign burst_hit = BURST_EN && (cnt_next == BURST_LIM);
  assign last_hit  = s_axis_tlast[m_axis_tid];
  // tlast and burst limit on the same beat still produce one release.
  assign release_grant = beat & (last_hit | burst_hit);

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state      <= S_IDLE;
      ogrant     <= '0;
      m_axis_tid <= '0;
      beat_cnt   <= '0;
      ptr        <= ID_W'(NUM_REQ - 1);
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_found) begin
            state      <= S_XFER;
            ogrant     <= pick_onehot;
            m_axis_tid <= pick_idx;
            beat_cnt   <= '0;
          end
        end
        S_XFER: begin
          if (beat) begin
            beat_cnt <= cnt_next;
          end
          // Always pass through IDLE after a release: this is the bubble
          // that keeps a re-asserted valid from the same requester from
          // being taken again before the others are considered.
          if (release_grant) begin
            state  <= S_IDLE;
            ptr    <= m_axis_tid;
            ogrant <= '0;
          end
        end
        default: begin
          state  <= S_IDLE;
          ogrant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sv_uart_tx_arbiter.sv
// Directed bench for sv_uart_tx_arbiter. Two instances share all inputs:
// dut0 with MAX_BURST=0 and dut4 with MAX_BURST=4. Inputs change on the
// falling edge and outputs are sampled 1 time unit later.

module tb_sv_uart_tx_arbiter;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic [95:0] s_tdata;
  logic [3:0]  s_tvalid;
  logic [3:0]  s_tlast;
  logic        m_tready;

  logic [3:0]  sready0, sready4;
  logic [23:0] mdata0, mdata4;
  logic        mvalid0, mvalid4;
  logic [1:0]  mtid0, mtid4;
  logic [3:0]  grant0, grant4;
  logic        busy0, busy4;

  int checks = 0;
  int errors = 0;

  int exp_busy3 [16];
  int exp_tid3  [16];
  int exp_dat3  [16];

  always #5 iclk = ~iclk;

  sv_uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(24), .MAX_BURST(0)) dut0 (
    .iclk(iclk), .irst(irst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(sready0),
    .m_axis_tdata(mdata0), .m_axis_tvalid(mvalid0), .m_axis_tready(m_tready),
    .m_axis_tid(mtid0), .ogrant(grant0), .obusy(busy0)
  );

  sv_uart_tx_arbiter #(.NUM_REQ(4), .DATA_WIDTH(24), .MAX_BURST(4)) dut4 (
    .iclk(iclk), .irst(irst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(sready4),
    .m_axis_tdata(mdata4), .m_axis_tvalid(mvalid4), .m_axis_tready(m_tready),
    .m_axis_tid(mtid4), .ogrant(grant4), .obusy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge iclk);
  endtask

  task automatic set_req(input int i, input logic [23:0] d, input logic v, input logic l);
    s_tdata[i*24 +: 24] = d;
    s_tvalid[i[1:0]]    = v;
    s_tlast[i[1:0]]     = l;
  endtask

  task automatic reset_dut();
    cyc();
    irst     = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;
    cyc();
    irst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0_n, r2_n, r3_n, eb;
    logic r1_done, r2_done, acc0, acc1, acc2, acc3, tr;

    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b1;

    exp_busy3 = '{0,1,1,1,1,0,1,0,1,1,1,1,0,1,1,0};
    exp_tid3  = '{0,0,0,0,0,0,2,0,0,0,0,0,0,0,0,0};
    exp_dat3  = '{0,'hA00000,'hA00001,'hA00002,'hA00003,0,'hC20000,0,
                  'hA00004,'hA00005,'hA00006,'hA00007,0,'hA00008,'hA00009,0};

    // Reset state
    cyc(); #1;
    chk("rst_grant",  32'(grant0),  32'h0);
    chk("rst_tid",    32'(mtid0),   32'h0);
    chk("rst_busy",   32'(busy0),   32'h0);
    chk("rst_mvalid", 32'(mvalid0), 32'h0);
    chk("rst_sready", 32'(sready0), 32'h0);
    chk("rst_grant4", 32'(grant4),  32'h0);

    // 1: requester 1 sends a 3-beat packet
    cyc();
    irst = 1'b0;
    set_req(1, 24'hA1A2A3, 1'b1, 1'b0);
    #1;
    chk("t1_idle_busy",   32'(busy0),   32'h0);
    chk("t1_idle_mvalid", 32'(mvalid0), 32'h0);
    chk("t1_idle_sready", 32'(sready0), 32'h0);
    cyc(); #1;
    chk("t1_b0_busy",   32'(busy0),   32'h1);
    chk("t1_b0_grant",  32'(grant0),  32'h2);
    chk("t1_b0_tid",    32'(mtid0),   32'h1);
    chk("t1_b0_mvalid", 32'(mvalid0), 32'h1);
    chk("t1_b0_data",   32'(mdata0),  32'hA1A2A3);
    chk("t1_b0_sready", 32'(sready0), 32'h2);
    cyc();
    set_req(1, 24'hB1B2B3, 1'b1, 1'b0);
    #1;
    chk("t1_b1_data", 32'(mdata0), 32'hB1B2B3);
    chk("t1_b1_tid",  32'(mtid0),  32'h1);
    cyc();
    set_req(1, 24'hC1C2C3, 1'b1, 1'b1);
    #1;
    chk("t1_b2_data",   32'(mdata0),  32'hC1C2C3);
    chk("t1_b2_sready", 32'(sready0), 32'h2);
    cyc();
    set_req(1, 24'h0, 1'b0, 1'b0);
    #1;
    chk("t1_end_busy",  32'(busy0),  32'h0);
    chk("t1_end_grant", 32'(grant0), 32'h0);

    // 2: four requesters with continuous 1-beat packets
    reset_dut();
    for (int i = 0; i < 4; i++) set_req(i, 24'(32'h100000 + i), 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t2_bubble_busy",   32'(busy0),   32'h0);
      chk("t2_bubble_mvalid", 32'(mvalid0), 32'h0);
      cyc(); #1;
      chk("t2_tid",   32'(mtid0),  32'(k % 4));
      chk("t2_grant", 32'(grant0), 32'(1 << (k % 4)));
      chk("t2_data",  32'(mdata0), 32'(32'h100000 + k % 4));
      chk("t2_beat",  32'(mvalid0 & m_tready), 32'h1);
      cyc();
    end

    // 3: MAX_BURST=4, requester 0 sends 10 beats while requester 2 waits
    reset_dut();
    r0_n = 0;
    r2_done = 1'b0;
    for (int c = 0; c < 16; c++) begin
      set_req(0, 24'(32'hA00000 + r0_n), r0_n < 10, r0_n == 9);
      set_req(2, 24'hC20000, !r2_done, 1'b1);
      #1;
      chk("t3_busy", 32'(busy4), 32'(exp_busy3[c]));
      if (exp_busy3[c] != 0) begin
        chk("t3_tid",  32'(mtid4),  32'(exp_tid3[c]));
        chk("t3_data", 32'(mdata4), 32'(exp_dat3[c]));
      end
      acc0 = sready4[0] & s_tvalid[0];
      acc2 = sready4[2] & s_tvalid[2];
      cyc();
      if (acc0) r0_n++;
      if (acc2) r2_done = 1'b1;
    end
    chk("t3_r0_beats", 32'(r0_n), 32'd10);
    chk("t3_r2_done",  32'(r2_done), 32'h1);

    // 4: engine stalls for 100 cycles inside a 4-beat packet
    reset_dut();
    r2_n = 0;
    for (int c = 0; c < 106; c++) begin
      tr = !(c >= 3 && c < 103);
      m_tready = tr;
      set_req(2, 24'(32'h200000 + r2_n), r2_n < 4, r2_n == 3);
      #1;
      if (c == 0 || c == 105) begin
        chk("t4_idle_busy", 32'(busy0), 32'h0);
      end else begin
        eb = (c <= 2) ? c - 1 : ((c < 103) ? 2 : c - 101);
        chk("t4_sready", 32'(sready0), tr ? 32'h4 : 32'h0);
        chk("t4_mvalid", 32'(mvalid0), 32'h1);
        chk("t4_data",   32'(mdata0),  32'(32'h200000 + eb));
      end
      acc2 = sready0[2] & s_tvalid[2];
      cyc();
      if (acc2) r2_n++;
    end
    chk("t4_beats", 32'(r2_n), 32'd4);
    m_tready = 1'b1;

    // 5: reset during beat 2 of a 5-beat packet
    reset_dut();
    r2_n = 0;
    for (int c = 0; c < 3; c++) begin
      set_req(2, 24'(32'h500000 + r2_n), 1'b1, r2_n == 4);
      #1;
      acc2 = sready0[2] & s_tvalid[2];
      cyc();
      if (acc2) r2_n++;
    end
    set_req(2, 24'(32'h500000 + r2_n), 1'b1, 1'b0);
    #1;
    chk("t5_b2_mvalid", 32'(mvalid0), 32'h1);
    chk("t5_b2_data",   32'(mdata0),  32'h500002);
    #1;
    irst = 1'b1;
    #1;
    chk("t5_rst_grant",  32'(grant0),  32'h0);
    chk("t5_rst_mvalid", 32'(mvalid0), 32'h0);
    chk("t5_rst_busy",   32'(busy0),   32'h0);
    chk("t5_rst_sready", 32'(sready0), 32'h0);
    cyc();
    irst = 1'b0;
    set_req(0, 24'h0A0000, 1'b1, 1'b1);
    set_req(2, 24'h500000, 1'b1, 1'b0);
    #1;
    chk("t5_after_idle", 32'(busy0), 32'h0);
    cyc(); #1;
    chk("t5_after_tid",   32'(mtid0),  32'h0);
    chk("t5_after_grant", 32'(grant0), 32'h1);
    chk("t5_after_data",  32'(mdata0), 32'h0A0000);

    // 6: requester 3 drops valid for 20 cycles mid-packet, requester 1 waits
    reset_dut();
    r3_n = 0;
    r1_done = 1'b0;
    for (int c = 0; c < 26; c++) begin
      set_req(3, 24'(32'h300000 + r3_n), (c <= 1 || c >= 22) && r3_n < 3, r3_n == 2);
      set_req(1, 24'h111111, c >= 1 && !r1_done, 1'b1);
      #1;
      if (c >= 1 && c <= 23) begin
        chk("t6_hold_grant",  32'(grant0),  32'h8);
        chk("t6_hold_tid",    32'(mtid0),   32'h3);
        chk("t6_hold_sready", 32'(sready0), 32'h8);
      end else if (c == 24) begin
        chk("t6_bubble_busy", 32'(busy0), 32'h0);
      end else if (c == 25) begin
        chk("t6_r1_tid",   32'(mtid0),  32'h1);
        chk("t6_r1_grant", 32'(grant0), 32'h2);
        chk("t6_r1_data",  32'(mdata0), 32'h111111);
      end
      acc3 = sready0[3] & s_tvalid[3];
      acc1 = sready0[1] & s_tvalid[1];
      cyc();
      if (acc3) r3_n++;
      if (acc1) r1_done = 1'b1;
    end
    chk("t6_r3_beats", 32'(r3_n), 32'd3);
    chk("t6_r1_done",  32'(r1_done), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
